// File: rtl/vga_draw_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter_if
//   Bundle between the drawing engines and the pixel-write arbiter.
//
//   Requester side (master modport drives):
//     hold        : freeze new grants while high
//     req_valid   : per-requester pixel valid / request
//     req_last    : per-requester end-of-burst marker
//     req_x/y/colour : packed per-requester pixel fields, requester i at
//                   [i*W +: W]
//   Arbiter side (slave modport drives):
//     req_ready   : per-requester ready (mirrors grant)
//     grant       : one-hot grant, zero when idle
//     busy        : a burst is in progress
//     timeout     : one-cycle pulse when an idle burst is revoked
//     x/y/colour/plot : registered write port toward vga_adapter
// ---------------------------------------------------------------------------
interface vga_draw_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3
);
  logic                   hold;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*X_W-1:0]   req_x;
  logic [N_REQ*Y_W-1:0]   req_y;
  logic [N_REQ*C_W-1:0]   req_colour;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   timeout;
  logic [X_W-1:0]         x;
  logic [Y_W-1:0]         y;
  logic [C_W-1:0]         colour;
  logic                   plot;

  modport master (
    output hold, req_valid, req_last, req_x, req_y, req_colour,
    input  req_ready, grant, busy, timeout, x, y, colour, plot
  );

  modport slave (
    input  hold, req_valid, req_last, req_x, req_y, req_colour,
    output req_ready, grant, busy, timeout, x, y, colour, plot
  );
endinterface

// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
//   Shares the single pixel-write port of the 160x120 VGA adapter between
//   N_REQ drawing engines. One engine is granted per burst in round-robin
//   order; pixels outside the screen are accepted but never plotted. The
//   write port (x/y/colour/plot) is registered, one cycle after transfer.
//
//   Ports:
//     clk     : system clock
//     resetn  : asynchronous active-low reset
//     bus     : vga_draw_arbiter_if.slave (requests in, grant and
//               adapter write port out)
// ---------------------------------------------------------------------------
module vga_draw_arbiter #(
  parameter int N_REQ    = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int MAX_IDLE = 16
) (
  input  logic                clk,
  input  logic                resetn,
  vga_draw_arbiter_if.slave   bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAX_IDLE > 1) ? $clog2(MAX_IDLE) : 1;

  typedef enum logic [0:0] {IDLE, BURST} state_t;

  // Pixel lies on screen; off-screen pixels are swallowed without a write.
  function automatic logic in_range(input logic [X_W-1:0] px,
                                    input logic [Y_W-1:0] py);
    return (32'(px) < 32'(H_RES)) && (32'(py) < 32'(V_RES));
  endfunction

  // Round-robin pointer increment wrapping at N_REQ, not a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == 32'(N_REQ - 1)) return '0;
    return p + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;

  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W:0]     scan_sum;

  logic [X_W-1:0]     fx [N_REQ];
  logic [Y_W-1:0]     fy [N_REQ];
  logic [C_W-1:0]     fc [N_REQ];

  logic               xfer_p0;
  logic               last_p0;
  logic               on_screen_p0;
  logic [X_W-1:0]     x_p0;
  logic [Y_W-1:0]     y_p0;
  logic [C_W-1:0]     colour_p0;

  logic               vld_p1;
  logic [X_W-1:0]     x_p1;
  logic [Y_W-1:0]     y_p1;
  logic [C_W-1:0]     colour_p1;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign fx[i] = bus.req_x[i*X_W +: X_W];
    assign fy[i] = bus.req_y[i*Y_W +: Y_W];
    assign fc[i] = bus.req_colour[i*C_W +: C_W];
  end

  // ---- stage p0: select granted requester, detect transfer ----
  assign x_p0         = fx[gidx_q];
  assign y_p0         = fy[gidx_q];
  assign colour_p0    = fc[gidx_q];
  assign xfer_p0      = (state_q == BURST) && bus.req_valid[gidx_q];
  assign last_p0      = bus.req_last[gidx_q];
  assign on_screen_p0 = in_range(x_p0, y_p0);

  // First requesting index at or after rr_ptr, modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      if (!pick_found && bus.req_valid[scan_sum[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sum[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    idle_cnt_d = idle_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.hold && pick_found) begin
          state_d           = BURST;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idle_cnt_d        = '0;
        end
      end
      BURST: begin
        if (xfer_p0) begin
          idle_cnt_d = '0;
          if (last_p0) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = wrap_inc(gidx_q);
          end
        end else if (idle_cnt_q == CNT_W'(MAX_IDLE - 1)) begin
          // Stalled engine: release the port so others are not starved.
          state_d   = IDLE;
          grant_d   = '0;
          rr_ptr_d  = wrap_inc(gidx_q);
          timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---- stage p1: registered adapter write port ----
  // Clipped pixels leave the previous coordinates in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1    <= 1'b0;
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
    end else begin
      vld_p1 <= xfer_p0 && on_screen_p0;
      if (xfer_p0 && on_screen_p0) begin
        x_p1      <= x_p0;
        y_p1      <= y_p0;
        colour_p1 <= colour_p0;
      end
    end
  end

  assign bus.req_ready = grant_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == BURST);
  assign bus.timeout   = timeout_q;
  assign bus.x         = x_p1;
  assign bus.y         = y_p1;
  assign bus.colour    = colour_p1;
  assign bus.plot      = vld_p1;

endmodule
